lsu_mc: RTL and testbench

Multi-cycle, parametrised load/store unit, successor to the single-cycle LSU. It has a valid/ready request handshake and a one-cycle response pulse, and contains an internal synchronous-read data memory with byte enables. Misaligned accesses can optionally be split into two word accesses. The memory-mapped IO registers (LEDR, LEDG, LCD, HEX) are readable, and the HEX display count is parametrised. It sits between the core's execute stage and memory/IO; the core stalls on o_req_ready and o_rsp_valid.

---
 rtl/lsu_mc_if.sv | 22 ++
 rtl/lsu_mc.sv | 194 +++++++++++++++++++
 tb/tb_lsu_mc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mc_if.sv
// Request/response bus between the core's execute stage and the LSU.
interface lsu_mc_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        i_lsu_wren;
  logic [2:0]  i_func3;
  logic        o_rsp_valid;
  logic [31:0] o_ld_data;
  logic        o_misalign;

  modport master (
    output i_req_valid, i_lsu_addr, i_st_data, i_lsu_wren, i_func3,
    input  o_req_ready, o_rsp_valid, o_ld_data, o_misalign
  );

  modport slave (
    input  i_req_valid, i_lsu_addr, i_st_data, i_lsu_wren, i_func3,
    output o_req_ready, o_rsp_valid, o_ld_data, o_misalign
  );
endinterface

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: registered request, synchronous-read data
// memory with byte enables, optional split of misaligned accesses, and
// readable memory-mapped IO (LEDR, LEDG, HEX, LCD, SW).
module lsu_mc #(
  parameter int DMEM_AW     = 16,
  parameter int N_HEX       = 8,
  parameter int LEDR_W      = 32,
  parameter int LEDG_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  lsu_mc_if.slave             lsu,
  input  logic [31:0]         i_io_sw,
  output logic [7*N_HEX-1:0]  o_io_hex,
  output logic [LEDR_W-1:0]   o_io_ledr,
  output logic [LEDG_W-1:0]   o_io_ledg,
  output logic [31:0]         o_io_lcd
);
  localparam int IW    = DMEM_AW - 2;
  localparam int DEPTH = 2 ** IW;

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_RESP} state_t;
  state_t r_state, w_next;

  logic [31:0]       r_addr, r_data;
  logic              r_wren;
  logic [2:0]        r_func3;
  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_mem_q, r_lo, r_io_q;
  logic [LEDR_W-1:0] r_ledr;
  logic [LEDG_W-1:0] r_ledg;
  logic [31:0]       r_lcd;
  logic [6:0]        r_hex [N_HEX];

  logic [1:0]  w_off;
  logic [19:0] w_page;
  logic        w_is_dmem, w_is_ledr, w_is_ledg, w_is_hex, w_is_lcd, w_is_sw;
  logic        w_f3_ok, w_mis_addr, w_err, w_split;
  logic [3:0]  w_mask;
  logic [7:0]  w_be8;
  logic [63:0] w_sh, w_cat;
  logic [31:0] w_raw, w_ext, w_io_rd;
  logic [IW-1:0] w_idx;
  logic        w_mem_wr, w_io_wr;
  logic [3:0]  w_mem_be;
  logic [31:0] w_mem_wd;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  // Decode of the registered request: target, legality, lanes and split need
  always_comb begin
    w_off      = r_addr[1:0];
    w_page     = r_addr[31:12];
    w_is_dmem  = ~r_addr[28];
    w_is_ledr  = (w_page == 20'h10000);
    w_is_ledg  = (w_page == 20'h10001);
    w_is_hex   = (w_page == 20'h10002) || (w_page == 20'h10003);
    w_is_lcd   = (w_page == 20'h10004);
    w_is_sw    = (w_page == 20'h10010);
    w_f3_ok    = 1'b0;
    case (r_func3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = ~r_wren;
      default:                w_f3_ok = 1'b0;
    endcase
    w_mis_addr = ((r_func3[1:0] == 2'b01) && w_off[0]) ||
                 ((r_func3[1:0] == 2'b10) && (w_off != 2'b00));
    w_err      = ~w_f3_ok || (w_mis_addr && ((MISALIGN_EN == 0) || ~w_is_dmem));
    w_split    = w_f3_ok && w_mis_addr && (MISALIGN_EN != 0) && w_is_dmem;
    case (r_func3[1:0])
      2'b00:   w_mask = 4'b0001;
      2'b01:   w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
    // Lanes and data for two consecutive words: low half to ACC1, high to ACC2
    w_be8    = {4'b0000, w_mask} << w_off;
    w_sh     = {32'b0, r_data} << {w_off, 3'b000};
    w_idx    = (r_state == S_ACC2) ? r_addr[DMEM_AW-1:2] + IW'(1) : r_addr[DMEM_AW-1:2];
    w_mem_be = (r_state == S_ACC2) ? w_be8[7:4] : w_be8[3:0];
    w_mem_wd = (r_state == S_ACC2) ? w_sh[63:32] : w_sh[31:0];
    w_mem_wr = w_is_dmem && r_wren && ~w_err && ~i_reset &&
               ((r_state == S_ACC1) || (r_state == S_ACC2));
    w_io_wr  = (r_state == S_ACC1) && r_wren && ~w_err;
  end

  // IO read-back value, captured during ACC1
  always_comb begin
    w_io_rd = '0;
    if (w_is_ledr)     w_io_rd = 32'(r_ledr);
    else if (w_is_ledg) w_io_rd = 32'(r_ledg);
    else if (w_is_lcd)  w_io_rd = r_lcd;
    else if (w_is_sw)   w_io_rd = i_io_sw;
    else if (w_is_hex) begin
      for (int unsigned k = 0; k < N_HEX; k++)
        if ((k / 4) == 32'(r_addr[12])) w_io_rd[8*(k%4) +: 8] = {1'b0, r_hex[k]};
    end
  end

  // Load result: concatenate split words little-endian, shift, then extend
  always_comb begin
    w_cat = w_split ? {r_mem_q, r_lo} : {32'b0, (w_is_dmem ? r_mem_q : r_io_q)};
    w_raw = 32'(w_cat >> {w_off, 3'b000});
    case (r_func3)
      3'b000:  w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_ext = {24'b0, w_raw[7:0]};
      3'b101:  w_ext = {16'b0, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (lsu.i_req_valid) w_next = S_ACC1;
      S_ACC1:  w_next = w_split ? S_ACC2 : S_RESP;
      S_ACC2:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture on acceptance
  always_ff @(posedge i_clk) begin
    if (r_state == S_IDLE && lsu.i_req_valid) begin
      r_addr  <= lsu.i_lsu_addr;
      r_data  <= lsu.i_st_data;
      r_wren  <= lsu.i_lsu_wren;
      r_func3 <= lsu.i_func3;
    end
  end

  // Data memory: per-byte write, synchronous read
  always_ff @(posedge i_clk) begin
    if (w_mem_wr)
      for (int unsigned b = 0; b < 4; b++)
        if (w_mem_be[b]) r_mem[w_idx][8*b +: 8] <= w_mem_wd[8*b +: 8];
    r_mem_q <= r_mem[w_idx];
  end

  // Hold first split word and the IO read value
  always_ff @(posedge i_clk) begin
    if (r_state == S_ACC2) r_lo   <= r_mem_q;
    if (r_state == S_ACC1) r_io_q <= w_io_rd;
  end

  // IO registers with lane-masked writes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ledr <= '0;
      r_ledg <= '0;
      r_lcd  <= '0;
      for (int unsigned k = 0; k < N_HEX; k++) r_hex[k] <= '0;
    end else if (w_io_wr) begin
      if (w_is_ledr) r_ledr <= LEDR_W'(f_merge(32'(r_ledr), w_sh[31:0], w_be8[3:0]));
      if (w_is_ledg) r_ledg <= LEDG_W'(f_merge(32'(r_ledg), w_sh[31:0], w_be8[3:0]));
      if (w_is_lcd)  r_lcd  <= f_merge(r_lcd, w_sh[31:0], w_be8[3:0]);
      if (w_is_hex)
        for (int unsigned k = 0; k < N_HEX; k++)
          if (((k / 4) == 32'(r_addr[12])) && w_be8[k%4])
            r_hex[k] <= w_sh[8*(k%4) +: 7];
    end
  end

  // Output packing
  always_comb begin
    o_io_hex = '0;
    for (int unsigned k = 0; k < N_HEX; k++) o_io_hex[7*k +: 7] = r_hex[k];
  end

  assign o_io_ledr       = r_ledr;
  assign o_io_ledg       = r_ledg;
  assign o_io_lcd        = r_lcd;
  assign lsu.o_req_ready = (r_state == S_IDLE);
  assign lsu.o_rsp_valid = (r_state == S_RESP);
  assign lsu.o_misalign  = (r_state == S_RESP) && w_err;
  assign lsu.o_ld_data   = ((r_state == S_RESP) && ~w_err) ? w_ext : '0;
endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench: dut0 splits misaligned accesses (12-bit dmem, 6 HEX digits),
// dut1 flags them as errors (default sizing).
module tb_lsu_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sw  = '0;
  logic [41:0] hex0;
  logic [55:0] hex1;
  logic [31:0] ledr0, ledg0, lcd0, ledr1, ledg1, lcd1;
  int n_chk  = 0;
  int n_fail = 0;

  lsu_mc_if if0();
  lsu_mc_if if1();

  lsu_mc #(.DMEM_AW(12), .N_HEX(6), .LEDR_W(32), .LEDG_W(32), .MISALIGN_EN(1)) dut0 (
    .i_clk(clk), .i_reset(rst), .lsu(if0), .i_io_sw(sw),
    .o_io_hex(hex0), .o_io_ledr(ledr0), .o_io_ledg(ledg0), .o_io_lcd(lcd0));

  lsu_mc #(.DMEM_AW(16), .N_HEX(8), .LEDR_W(32), .LEDG_W(32), .MISALIGN_EN(0)) dut1 (
    .i_clk(clk), .i_reset(rst), .lsu(if1), .i_io_sw(sw),
    .o_io_hex(hex1), .o_io_ledr(ledr1), .o_io_ledg(ledg1), .o_io_lcd(lcd1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic rsp(input int sel);
    return (sel == 0) ? if0.o_rsp_valid : if1.o_rsp_valid;
  endfunction

  task automatic do_req(input int sel, input logic [31:0] addr, input logic [31:0] data,
                        input logic wren, input logic [2:0] f3,
                        output logic [31:0] ld, output logic mis, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!((sel == 0) ? if0.o_req_ready : if1.o_req_ready) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sel == 0) begin
      if0.i_lsu_addr = addr; if0.i_st_data = data; if0.i_lsu_wren = wren;
      if0.i_func3 = f3; if0.i_req_valid = 1'b1;
    end else begin
      if1.i_lsu_addr = addr; if1.i_st_data = data; if1.i_lsu_wren = wren;
      if1.i_func3 = f3; if1.i_req_valid = 1'b1;
    end
    @(posedge clk); #1;
    if0.i_req_valid = 1'b0;
    if1.i_req_valid = 1'b0;
    lat = 1;
    while (!rsp(sel) && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    ld  = (sel == 0) ? if0.o_ld_data  : if1.o_ld_data;
    mis = (sel == 0) ? if0.o_misalign : if1.o_misalign;
    @(posedge clk); #1;
    chk({tag_of(addr), "_rsp_pulse"}, 64'(rsp(sel)), 64'd0);
  endtask

  function automatic string tag_of(input logic [31:0] a);
    return $sformatf("a%08h", a);
  endfunction

  task automatic st(input string tag, input int sel, input logic [31:0] addr,
                    input logic [31:0] data, input logic [2:0] f3,
                    input logic exp_mis, input int exp_lat);
    logic [31:0] ld; logic mis; int lat;
    do_req(sel, addr, data, 1'b1, f3, ld, mis, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_mis"}, 64'(mis), 64'(exp_mis));
  endtask

  task automatic ldc(input string tag, input int sel, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] exp_d,
                     input logic exp_mis, input int exp_lat);
    logic [31:0] ld; logic mis; int lat;
    do_req(sel, addr, 32'h0, 1'b0, f3, ld, mis, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, 64'(ld), 64'(exp_d));
    chk({tag, "_mis"}, 64'(mis), 64'(exp_mis));
  endtask

  initial begin : main
    logic [41:0] exp_hex;
    if0.i_req_valid = 1'b0; if0.i_lsu_addr = '0; if0.i_st_data = '0;
    if0.i_lsu_wren = 1'b0; if0.i_func3 = '0;
    if1.i_req_valid = 1'b0; if1.i_lsu_addr = '0; if1.i_st_data = '0;
    if1.i_lsu_wren = 1'b0; if1.i_func3 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(if0.o_req_ready), 64'd1);
    chk("rst_rsp",   64'(if0.o_rsp_valid), 64'd0);
    chk("rst_ld",    64'(if0.o_ld_data), 64'd0);
    chk("rst_mis",   64'(if0.o_misalign), 64'd0);
    chk("rst_hex",   64'(hex0), 64'd0);
    chk("rst_ledr",  64'(ledr0), 64'd0);
    chk("rst_ledg",  64'(ledg0), 64'd0);
    chk("rst_lcd",   64'(lcd0), 64'd0);
    @(negedge clk) rst = 1'b0;

    // 1: aligned word store/load
    st ("sw10", 0, 32'h0000_0010, 32'h1234_5678, 3'b010, 1'b0, 2);
    ldc("lw10", 0, 32'h0000_0010, 3'b010, 32'h1234_5678, 1'b0, 2);

    // 2: byte store and signed/unsigned byte loads
    st ("sb13", 0, 32'h0000_0013, 32'h0000_00AB, 3'b000, 1'b0, 2);
    ldc("lb13", 0, 32'h0000_0013, 3'b000, 32'hFFFF_FFAB, 1'b0, 2);
    ldc("lbu13", 0, 32'h0000_0013, 3'b100, 32'h0000_00AB, 1'b0, 2);
    ldc("lw10b", 0, 32'h0000_0010, 3'b010, 32'hAB34_5678, 1'b0, 2);
    ldc("lh12", 0, 32'h0000_0012, 3'b001, 32'hFFFF_AB34, 1'b0, 2);

    // 3: split word store/load, then wrap at the last word
    st ("clr20", 0, 32'h0000_0020, 32'h0, 3'b010, 1'b0, 2);
    st ("clr24", 0, 32'h0000_0024, 32'h0, 3'b010, 1'b0, 2);
    st ("sw22", 0, 32'h0000_0022, 32'hDEAD_BEEF, 3'b010, 1'b0, 3);
    ldc("lw22", 0, 32'h0000_0022, 3'b010, 32'hDEAD_BEEF, 1'b0, 3);
    ldc("lw20", 0, 32'h0000_0020, 3'b010, 32'hBEEF_0000, 1'b0, 2);
    ldc("lw24", 0, 32'h0000_0024, 3'b010, 32'h0000_DEAD, 1'b0, 2);
    st ("clr00", 0, 32'h0000_0000, 32'h0, 3'b010, 1'b0, 2);
    st ("swFFE", 0, 32'h0000_0FFE, 32'hCAFE_F00D, 3'b010, 1'b0, 3);
    ldc("lw00", 0, 32'h0000_0000, 3'b010, 32'h0000_CAFE, 1'b0, 2);
    ldc("lwFFE", 0, 32'h0000_0FFE, 3'b010, 32'hCAFE_F00D, 1'b0, 3);
    ldc("lhFFF", 0, 32'h0000_0FFF, 3'b001, 32'hFFFF_FEF0, 1'b0, 3);

    // 4: errors - misalignment without splitting, illegal func3, misaligned IO
    st ("d1sw0", 1, 32'h0000_0000, 32'h1122_3344, 3'b010, 1'b0, 2);
    ldc("d1lh1", 1, 32'h0000_0001, 3'b001, 32'h0, 1'b1, 2);
    st ("d1sw2", 1, 32'h0000_0002, 32'hFFFF_FFFF, 3'b010, 1'b1, 2);
    ldc("d1lw0", 1, 32'h0000_0000, 3'b010, 32'h1122_3344, 1'b0, 2);
    ldc("ill3", 0, 32'h0000_0010, 3'b011, 32'h0, 1'b1, 2);
    st ("illst5", 0, 32'h0000_0010, 32'hFFFF_FFFF, 3'b101, 1'b1, 2);
    ldc("lw10c", 0, 32'h0000_0010, 3'b010, 32'hAB34_5678, 1'b0, 2);
    ldc("ioMis", 0, 32'h1000_0002, 3'b010, 32'h0, 1'b1, 2);

    // 5: HEX with 6 digits, then LEDR/LEDG/LCD/SW/unmapped
    st ("hexW", 0, 32'h1000_3000, 32'h7F3F_067F, 3'b010, 1'b0, 2);
    exp_hex = '0;
    exp_hex[34:28] = 7'h7F;
    exp_hex[41:35] = 7'h06;
    chk("hex_w", 64'(hex0), 64'(exp_hex));
    st ("hexB", 0, 32'h1000_2001, 32'h0000_005B, 3'b000, 1'b0, 2);
    exp_hex[13:7] = 7'h5B;
    chk("hex_b", 64'(hex0), 64'(exp_hex));
    ldc("hexRd0", 0, 32'h1000_2000, 3'b010, 32'h0000_5B00, 1'b0, 2);
    ldc("hexRd1", 0, 32'h1000_3000, 3'b010, 32'h0000_067F, 1'b0, 2);
    st ("ledrH", 0, 32'h1000_0002, 32'h0000_BEEF, 3'b001, 1'b0, 2);
    chk("ledr_val", 64'(ledr0), 64'h0000_0000_BEEF_0000);
    ldc("ledrLhu", 0, 32'h1000_0002, 3'b101, 32'h0000_BEEF, 1'b0, 2);
    ldc("ledrLh", 0, 32'h1000_0002, 3'b001, 32'hFFFF_BEEF, 1'b0, 2);
    st ("ledgW", 0, 32'h1000_1000, 32'h00C0_FFEE, 3'b010, 1'b0, 2);
    chk("ledg_val", 64'(ledg0), 64'h0000_0000_00C0_FFEE);
    st ("lcdB", 0, 32'h1000_4003, 32'h0000_0041, 3'b000, 1'b0, 2);
    chk("lcd_val", 64'(lcd0), 64'h0000_0000_4100_0000);
    ldc("lcdLbu", 0, 32'h1000_4003, 3'b100, 32'h0000_0041, 1'b0, 2);
    st ("swSt", 0, 32'h1001_0000, 32'h0000_0001, 3'b010, 1'b0, 2);
    ldc("unmap", 0, 32'h1000_5000, 3'b010, 32'h0, 1'b0, 2);
    st ("unmapSt", 0, 32'h1000_5000, 32'h1, 3'b010, 1'b0, 2);

    // 6: reset in ACC1 of a load
    @(negedge clk);
    if0.i_lsu_addr = 32'h0000_0010; if0.i_lsu_wren = 1'b0;
    if0.i_func3 = 3'b010; if0.i_req_valid = 1'b1;
    @(posedge clk); #1;
    if0.i_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rr_rsp",   64'(if0.o_rsp_valid), 64'd0);
    chk("rr_ready", 64'(if0.o_req_ready), 64'd1);
    chk("rr_hex",   64'(hex0), 64'd0);
    chk("rr_ledr",  64'(ledr0), 64'd0);
    chk("rr_ledg",  64'(ledg0), 64'd0);
    chk("rr_lcd",   64'(lcd0), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rr_norsp", 64'(if0.o_rsp_valid), 64'd0);
    end
    ldc("rr_mem", 0, 32'h0000_0010, 3'b010, 32'hAB34_5678, 1'b0, 2);
    sw = 32'h0000_00A5;
    ldc("swLbu", 0, 32'h1001_0000, 3'b100, 32'h0000_00A5, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
